hazard_stall_unit: RTL and testbench

//  Producer side of the EX-stage operand bypass: decides when the ID-stage instruction must not advance.

---
 rtl/hazard_stall_unit_pkg.sv | 36 +++
 rtl/hazard_stall_unit_if.sv | 28 ++
 rtl/hazard_stall_unit_mdu_busy_timer.sv | 42 ++++
 rtl/hazard_stall_unit.sv | 79 +++++++
 tb/tb_hazard_stall_unit.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared opcode/funct encodings and instruction classification for the ID-stage hazard logic.
package hazard_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  localparam int MDU_LAT_DEF = 32;

  typedef enum logic [1:0] {
    CLS_OTHER   = 2'd0,
    CLS_MULDIV  = 2'd1,
    CLS_HILO_RD = 2'd2
  } inst_cls_e;

  function automatic inst_cls_e classify(input logic [31:0] inst);
    inst_cls_e cls;
    cls = CLS_OTHER;
    if (inst[31:26] == OP_SPECIAL) begin
      if (inst[5:0] == F_MULT || inst[5:0] == F_MULTU ||
          inst[5:0] == F_DIV  || inst[5:0] == F_DIVU)
        cls = CLS_MULDIV;
      else if (inst[5:0] == F_MFHI || inst[5:0] == F_MFLO)
        cls = CLS_HILO_RD;
    end
    return cls;
  endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// ID-stage hazard bus: decoded ID instruction and EX branch outcome in, pipeline control out.
interface hazard_stall_unit_if #(
  parameter int PERF_W = 32
);
  logic              id_valid;
  logic [31:0]       id_inst;
  logic [4:0]        id_rd;
  logic              id_is_load;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic              ex_br_taken;
  logic              stall_pc;
  logic              stall_if_id;
  logic              bubble_id_ex;
  logic              flush_if_id;
  logic              mdu_busy;
  logic [PERF_W-1:0] perf_stall_cnt;

  modport master (
    output id_valid, id_inst, id_rd, id_is_load, id_uses_rs, id_uses_rt, ex_br_taken,
    input  stall_pc, stall_if_id, bubble_id_ex, flush_if_id, mdu_busy, perf_stall_cnt
  );

  modport slave (
    input  id_valid, id_inst, id_rd, id_is_load, id_uses_rs, id_uses_rt, ex_br_taken,
    output stall_pc, stall_if_id, bubble_id_ex, flush_if_id, mdu_busy, perf_stall_cnt
  );
endinterface

// File: rtl/hazard_stall_unit_mdu_busy_timer.sv
// MUL/DIV busy timer. The issue cycle counts as the first busy cycle, so busy is seen by
// the following MDU_LAT-1 cycles and a waiting consumer issues exactly MDU_LAT cycles later.
module mdu_busy_timer #(
  parameter int MDU_LAT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  output logic o_busy
);
  localparam int CNT_W = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MDU_LAT - 1);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start && (MDU_LAT > 1)) begin
            r_state <= ST_BUSY;
            r_count <= LOAD_VAL;
          end
        end
        ST_BUSY: begin
          r_count <= r_count - CNT_W'(1);
          if (r_count == CNT_W'(1))
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy = (r_state == ST_BUSY);
endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage stall/flush control: load-use detection, MUL/DIV busy interlock and branch flush,
// plus a saturating count of PC-stall cycles.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEF,
  parameter int PERF_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_stall_unit_if.slave bus
);
  logic [4:0]        r_ex_rd;
  logic              r_ex_load;
  logic [PERF_W-1:0] r_perf;

  logic [4:0] w_rs;
  logic [4:0] w_rt;
  inst_cls_e  w_cls;
  logic       w_mdu_busy;
  logic       w_load_use;
  logic       w_mdu_hz;
  logic       w_stall;
  logic       w_br;
  logic       w_stall_out;
  logic       w_bubble;
  logic       w_mdu_start;

  assign w_rs  = bus.id_inst[25:21];
  assign w_rt  = bus.id_inst[20:16];
  assign w_cls = classify(bus.id_inst);

  // Only a load in EX needs a stall; every other RAW case is covered by forwarding.
  assign w_load_use = r_ex_load && (r_ex_rd != 5'd0) &&
                      ((bus.id_uses_rs && (w_rs == r_ex_rd)) ||
                       (bus.id_uses_rt && (w_rt == r_ex_rd)));
  assign w_mdu_hz   = bus.id_valid && w_mdu_busy && (w_cls != CLS_OTHER);
  assign w_stall    = bus.id_valid && (w_load_use || w_mdu_hz);

  // Flush wins over stall; gating with rst_n keeps every output quiet while reset is held.
  assign w_br        = bus.ex_br_taken && rst_n;
  assign w_stall_out = w_stall && !w_br;
  assign w_bubble    = w_br || w_stall_out;
  assign w_mdu_start = bus.id_valid && (w_cls == CLS_MULDIV) && !w_stall && !w_br;

  mdu_busy_timer #(.MDU_LAT(MDU_LAT)) u_mdu_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_mdu_start),
    .o_busy  (w_mdu_busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_rd   <= 5'd0;
      r_ex_load <= 1'b0;
    end else if (w_bubble || !bus.id_valid) begin
      r_ex_rd   <= 5'd0;
      r_ex_load <= 1'b0;
    end else begin
      r_ex_rd   <= bus.id_rd;
      r_ex_load <= bus.id_is_load;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_perf <= '0;
    else if (w_stall_out && (r_perf != {PERF_W{1'b1}}))
      r_perf <= r_perf + PERF_W'(1);
  end

  assign bus.stall_pc       = w_stall_out;
  assign bus.stall_if_id    = w_stall_out;
  assign bus.bubble_id_ex   = w_bubble;
  assign bus.flush_if_id    = w_br;
  assign bus.mdu_busy       = w_mdu_busy;
  assign bus.perf_stall_cnt = r_perf;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: directed hazard scenarios followed by random traffic,
// checked against a cycle-level reference model of the hazard rules.
module tb_hazard_stall_unit;
  localparam int MDU_LAT = 4;
  localparam int PERF_W  = 2;
  localparam int PERF_MAX = (1 << PERF_W) - 1;

  typedef struct {
    logic spc;
    logic sif;
    logic bub;
    logic fl;
    logic busy;
    int   perf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_stall_unit_if #(.PERF_W(PERF_W)) bus ();

  hazard_stall_unit #(.MDU_LAT(MDU_LAT), .PERF_W(PERF_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: what advanced into EX last cycle, and the cycle at which MUL/DIV frees up.
  int         cyc = 0;
  logic [4:0] last_rd = 5'd0;
  logic       last_load = 1'b0;
  int         mdu_free_at = 0;
  int         perf = 0;

  function automatic logic [31:0] r_inst(input logic [4:0] rs, rt, rd, input logic [5:0] funct);
    return {6'd0, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] i_inst(input logic [5:0] op, input logic [4:0] rs, rt);
    return {op, rs, rt, 16'h0004};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic valid, input logic [31:0] inst,
                      input logic [4:0] rd, input logic ld, input logic urs, input logic urt,
                      input logic br);
    exp_t e;
    logic md, hl, busy, lu, stall, adv;
    @(posedge clk);
    #1;
    rst_n           = rst;
    bus.id_valid    = valid;
    bus.id_inst     = inst;
    bus.id_rd       = rd;
    bus.id_is_load  = ld;
    bus.id_uses_rs  = urs;
    bus.id_uses_rt  = urt;
    bus.ex_br_taken = br;
    if (!rst) begin
      e = '{spc: 0, sif: 0, bub: 0, fl: 0, busy: 0, perf: 0};
      last_rd = 5'd0; last_load = 1'b0; mdu_free_at = 0; perf = 0;
    end else begin
      md = (inst[31:26] == 6'd0) && (inst[5:0] inside {6'h18, 6'h19, 6'h1A, 6'h1B});
      hl = (inst[31:26] == 6'd0) && (inst[5:0] inside {6'h10, 6'h12});
      busy  = (cyc < mdu_free_at);
      lu    = last_load && (last_rd != 0) &&
              ((urs && inst[25:21] == last_rd) || (urt && inst[20:16] == last_rd));
      stall = valid && (lu || (busy && (md || hl)));
      e.fl   = br;
      e.bub  = br || stall;
      e.spc  = !br && stall;
      e.sif  = e.spc;
      e.busy = busy;
      e.perf = perf;
      if (e.spc && perf < PERF_MAX) perf++;
      adv       = valid && !e.bub;
      last_rd   = adv ? rd : 5'd0;
      last_load = adv ? ld : 1'b0;
      if (adv && md) mdu_free_at = cyc + MDU_LAT;
    end
    q.push_back(e);
    cyc++;
  endtask

  task automatic nop();
    step(1, 0, 32'd0, 5'd0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall_pc",       int'(bus.stall_pc),       int'(e.spc));
        chk("stall_if_id",    int'(bus.stall_if_id),    int'(e.sif));
        chk("bubble_id_ex",   int'(bus.bubble_id_ex),   int'(e.bub));
        chk("flush_if_id",    int'(bus.flush_if_id),    int'(e.fl));
        chk("mdu_busy",       int'(bus.mdu_busy),       int'(e.busy));
        chk("perf_stall_cnt", int'(bus.perf_stall_cnt), e.perf);
      end
    end
  end

  initial begin : stimulus
    logic [31:0] add98, mflo, mult, dvd, lw8, lu_add;
    int k;
    add98 = r_inst(5'd8, 5'd8, 5'd9, 6'h20);
    mflo  = r_inst(5'd0, 5'd0, 5'd10, 6'h12);
    mult  = r_inst(5'd4, 5'd5, 5'd0, 6'h18);
    dvd   = r_inst(5'd4, 5'd5, 5'd0, 6'h1A);
    lw8   = i_inst(6'h23, 5'd29, 5'd8);
    lu_add = r_inst(5'd3, 5'd8, 5'd11, 6'h20);
    bus.id_valid = 0; bus.id_inst = 0; bus.id_rd = 0; bus.id_is_load = 0;
    bus.id_uses_rs = 0; bus.id_uses_rt = 0; bus.ex_br_taken = 0;

    // Held reset: outputs silent even with a branch and a load presented.
    step(0, 1, lw8, 5'd8, 1, 1, 0, 1);
    step(0, 1, add98, 5'd9, 0, 1, 1, 0);
    step(1, 1, add98, 5'd9, 0, 1, 1, 0);

    // Load-use: one-cycle stall, then the consumer advances.
    step(1, 1, lw8, 5'd8, 1, 1, 0, 0);
    step(1, 1, add98, 5'd9, 0, 1, 1, 0);
    step(1, 1, add98, 5'd9, 0, 1, 1, 0);
    nop();

    // No stall: load to $0, and a consumer that does not read the loaded register.
    step(1, 1, i_inst(6'h23, 5'd29, 5'd0), 5'd0, 1, 1, 0, 0);
    step(1, 1, r_inst(5'd0, 5'd0, 5'd9, 6'h20), 5'd9, 0, 1, 1, 0);
    step(1, 1, lw8, 5'd8, 1, 1, 0, 0);
    step(1, 1, i_inst(6'h09, 5'd4, 5'd8), 5'd8, 0, 1, 0, 0);
    nop();

    // MUL then MFLO: three stall cycles, issue on the fourth.
    step(1, 1, mult, 5'd0, 0, 1, 1, 0);
    for (k = 0; k < 4; k++) step(1, 1, mflo, 5'd10, 0, 0, 0, 0);
    nop();

    // Branch taken over a load-use: flush beats stall, EX tracks nothing afterwards.
    step(1, 1, lw8, 5'd8, 1, 1, 0, 0);
    step(1, 1, add98, 5'd9, 0, 1, 1, 1);
    step(1, 1, add98, 5'd9, 0, 1, 1, 0);
    nop();

    // Branch cancels a MUL in ID; a later DIV starts a full timer.
    step(1, 1, mult, 5'd0, 0, 1, 1, 1);
    step(1, 1, mflo, 5'd10, 0, 0, 0, 0);
    step(1, 1, dvd, 5'd0, 0, 1, 1, 0);
    for (k = 0; k < MDU_LAT; k++) nop();

    // Reset in the middle of an MDU stall.
    step(1, 1, mult, 5'd0, 0, 1, 1, 0);
    step(1, 1, mflo, 5'd10, 0, 0, 0, 0);
    step(1, 1, mflo, 5'd10, 0, 0, 0, 0);
    step(0, 1, mflo, 5'd10, 0, 0, 0, 0);
    step(0, 1, mflo, 5'd10, 0, 0, 0, 0);
    step(1, 1, mflo, 5'd10, 0, 0, 0, 0);

    // Enough load-use stalls to saturate the 2-bit counter.
    for (k = 0; k < 5; k++) begin
      step(1, 1, lw8, 5'd8, 1, 1, 0, 0);
      step(1, 1, lu_add, 5'd11, 0, 1, 1, 0);
    end
    nop();

    for (k = 0; k < 400; k++) begin : rnd
      logic [4:0] rs, rt, rd;
      logic [31:0] inst;
      logic ld, urs, urt, v, br, rst;
      int kind;
      rs = 5'($urandom_range(0, 3));
      rt = 5'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 3));
      kind = $urandom_range(0, 5);
      ld = 0; urs = 1; urt = 1;
      case (kind)
        0: inst = r_inst(rs, rt, rd, 6'h20);
        1: begin inst = r_inst(rs, rt, 5'd0, 6'(6'h18 + $urandom_range(0, 3))); rd = 0; end
        2: begin inst = r_inst(5'd0, 5'd0, rd, ($urandom_range(0, 1) != 0) ? 6'h10 : 6'h12);
                 urs = 0; urt = 0; end
        3: begin inst = i_inst(6'h23, rs, rd); ld = 1; urt = 0; end
        4: begin inst = i_inst(6'h2B, rs, rt); rd = 0; end
        default: begin inst = i_inst(6'h09, rs, rd); urt = 0; end
      endcase
      v   = ($urandom_range(0, 7) != 0);
      br  = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 63) != 0);
      step(rst, v, inst, rd, ld, urs, urt, br);
    end
    nop();

    for (k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
